// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-master round-robin arbiter that serialises a CPU port (master 0) and a
// secondary DMA/video port (master 1) onto one single-port RAM. Each granted
// transaction spends READ_LATENCY cycles in ACCESS with the RAM signals held
// stable, then one RESP cycle where the winning master's ACK is high.
// All outputs come straight from registers.
module ram_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  // Legal range 1..15; the latency counter is 4 bits wide.
  parameter int READ_LATENCY = 1
) (
  input  logic              wire_clock,
  input  logic              wire_reset_n,

  input  logic              wire_M0_REQ,
  input  logic              wire_M0_RW,
  input  logic [ADDR_W-1:0] bus_M0_ADDRESS,
  input  logic [DATA_W-1:0] bus_M0_DATA_IN,
  output logic [DATA_W-1:0] bus_M0_DATA_OUT,
  output logic              wire_M0_ACK,

  input  logic              wire_M1_REQ,
  input  logic              wire_M1_RW,
  input  logic [ADDR_W-1:0] bus_M1_ADDRESS,
  input  logic [DATA_W-1:0] bus_M1_DATA_IN,
  output logic [DATA_W-1:0] bus_M1_DATA_OUT,
  output logic              wire_M1_ACK,

  output logic [ADDR_W-1:0] bus_RAM_ADDRESS,
  output logic              wire_RW,
  output logic [DATA_W-1:0] bus_RAM_DATA_IN,
  input  logic [DATA_W-1:0] bus_RAM_DATA_OUT
);

  // ACCESS lasts cnt+1 cycles, so loading LATENCY-1 gives exactly
  // READ_LATENCY cycles of stable address/data (and of wire_RW for writes).
  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Per-master request views, indexed by master id.
  logic [1:0]        req_vec;
  logic [1:0]        rw_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [DATA_W-1:0] wdata_vec [2];

  // FSM and datapath registers.
  state_t            state_reg;
  logic              grant_reg;       // master owning the current transaction
  logic              last_grant_reg;  // master granted most recently
  logic              write_reg;       // current transaction is a write
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic              ram_rw_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic [DATA_W-1:0] rdata_reg [2];
  logic [1:0]        ack_reg;

  // Arbitration decision for the current IDLE cycle.
  logic              pick_valid;
  logic              pick_id;

  assign req_vec      = {wire_M1_REQ, wire_M0_REQ};
  assign rw_vec       = {wire_M1_RW,  wire_M0_RW};
  assign addr_vec[0]  = bus_M0_ADDRESS;
  assign addr_vec[1]  = bus_M1_ADDRESS;
  assign wdata_vec[0] = bus_M0_DATA_IN;
  assign wdata_vec[1] = bus_M1_DATA_IN;

  // Pick the requester; on a tie the master that did not win last time goes.
  always_comb begin
    pick_valid = |req_vec;
    pick_id    = 1'b0;
    if (req_vec[0] && req_vec[1]) begin
      pick_id = ~last_grant_reg;
    end else if (req_vec[1]) begin
      pick_id = 1'b1;
    end
  end

  // Main FSM: grant in IDLE, hold the RAM port through ACCESS, pulse ACK in RESP.
  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;  // so master 0 wins the first tie
      write_reg      <= 1'b0;
      cnt_reg        <= 4'd0;
      ram_addr_reg   <= '0;
      ram_rw_reg     <= 1'b0;
      ram_wdata_reg  <= '0;
      rdata_reg[0]   <= '0;
      rdata_reg[1]   <= '0;
      ack_reg        <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Address and write data keep their last values while idle.
          ack_reg    <= 2'b00;
          ram_rw_reg <= 1'b0;
          if (pick_valid) begin
            grant_reg      <= pick_id;
            last_grant_reg <= pick_id;
            write_reg      <= rw_vec[pick_id];
            ram_addr_reg   <= addr_vec[pick_id];
            ram_wdata_reg  <= wdata_vec[pick_id];
            ram_rw_reg     <= rw_vec[pick_id];
            cnt_reg        <= CNT_LOAD;
            state_reg      <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            // Read data is valid on this edge; writes leave DATA_OUT alone.
            if (!write_reg) begin
              rdata_reg[grant_reg] <= bus_RAM_DATA_OUT;
            end
            ram_rw_reg         <= 1'b0;
            ack_reg[grant_reg] <= 1'b1;
            state_reg          <= ST_RESP;
          end
        end

        ST_RESP: begin
          // Requests are deliberately ignored here; a held REQ is seen in IDLE.
          ack_reg   <= 2'b00;
          state_reg <= ST_IDLE;
        end

        default: begin
          ack_reg    <= 2'b00;
          ram_rw_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_RAM_ADDRESS = ram_addr_reg;
  assign wire_RW         = ram_rw_reg;
  assign bus_RAM_DATA_IN = ram_wdata_reg;
  assign bus_M0_DATA_OUT = rdata_reg[0];
  assign bus_M1_DATA_OUT = rdata_reg[1];
  assign wire_M0_ACK     = ack_reg[0];
  assign wire_M1_ACK     = ack_reg[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter. Instance dut uses READ_LATENCY=1 with a
// combinational-read RAM model; instance dut3 uses READ_LATENCY=3 with a RAM
// model whose read data trails the address by two registers. Cycle counts are
// counted from the negedge where REQ is driven: the next posedge (the grant
// edge) is cycle 1, so ACK is seen at cycle READ_LATENCY+1.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  logic wire_clock = 1'b0;
  always #5 wire_clock = ~wire_clock;

  logic wire_reset_n;
  logic tb_init = 1'b1;

  // READ_LATENCY = 1 instance
  logic        m0_req, m0_rw, m0_ack, m1_req, m1_rw, m1_ack;
  logic [15:0] m0_addr, m0_din, m0_dout, m1_addr, m1_din, m1_dout;
  logic [15:0] ram_addr, ram_din, ram_dout;
  logic        ram_rw;

  // READ_LATENCY = 3 instance
  logic        d3_m0_req, d3_m0_rw, d3_m0_ack, d3_m1_ack;
  logic [15:0] d3_m0_addr, d3_m0_din, d3_m0_dout, d3_m1_dout;
  logic [15:0] d3_ram_addr, d3_ram_din, d3_ram_dout;
  logic        d3_ram_rw;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] mem  [256];
  logic [15:0] mem3 [256];
  logic [15:0] pipe3_a, pipe3_b;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(1)) dut (
    .wire_clock(wire_clock), .wire_reset_n(wire_reset_n),
    .wire_M0_REQ(m0_req), .wire_M0_RW(m0_rw), .bus_M0_ADDRESS(m0_addr),
    .bus_M0_DATA_IN(m0_din), .bus_M0_DATA_OUT(m0_dout), .wire_M0_ACK(m0_ack),
    .wire_M1_REQ(m1_req), .wire_M1_RW(m1_rw), .bus_M1_ADDRESS(m1_addr),
    .bus_M1_DATA_IN(m1_din), .bus_M1_DATA_OUT(m1_dout), .wire_M1_ACK(m1_ack),
    .bus_RAM_ADDRESS(ram_addr), .wire_RW(ram_rw),
    .bus_RAM_DATA_IN(ram_din), .bus_RAM_DATA_OUT(ram_dout)
  );

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(3)) dut3 (
    .wire_clock(wire_clock), .wire_reset_n(wire_reset_n),
    .wire_M0_REQ(d3_m0_req), .wire_M0_RW(d3_m0_rw), .bus_M0_ADDRESS(d3_m0_addr),
    .bus_M0_DATA_IN(d3_m0_din), .bus_M0_DATA_OUT(d3_m0_dout), .wire_M0_ACK(d3_m0_ack),
    .wire_M1_REQ(1'b0), .wire_M1_RW(1'b0), .bus_M1_ADDRESS(16'h0000),
    .bus_M1_DATA_IN(16'h0000), .bus_M1_DATA_OUT(d3_m1_dout), .wire_M1_ACK(d3_m1_ack),
    .bus_RAM_ADDRESS(d3_ram_addr), .wire_RW(d3_ram_rw),
    .bus_RAM_DATA_IN(d3_ram_din), .bus_RAM_DATA_OUT(d3_ram_dout)
  );

  // RAM model for dut: combinational read, write on the clock edge.
  assign ram_dout = mem[ram_addr[7:0]];
  always @(posedge wire_clock) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h00] <= 16'h1234;
      mem[8'h10] <= 16'h1111;
      mem[8'h20] <= 16'h2222;
    end else if (ram_rw) begin
      mem[ram_addr[7:0]] <= ram_din;
    end
  end

  // RAM model for dut3: read data trails the address by two registers.
  assign d3_ram_dout = pipe3_b;
  always @(posedge wire_clock) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 16'h0000;
      mem3[8'h42] <= 16'hCAFE;
      pipe3_a <= 16'h0000;
      pipe3_b <= 16'h0000;
    end else begin
      pipe3_a <= mem3[d3_ram_addr[7:0]];
      pipe3_b <= pipe3_a;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wire_clock);
    @(negedge wire_clock);
  endtask

  // Issue one request from master m at a negedge and wait (bounded) for its ACK.
  // Returns at the negedge where ACK is high, with REQ already dropped.
  task automatic run_one(input int m, input logic rw, input logic [15:0] addr,
                         input logic [15:0] din, output int cyc);
    logic seen;
    if (m == 0) begin m0_req = 1'b1; m0_rw = rw; m0_addr = addr; m0_din = din; end
    else        begin m1_req = 1'b1; m1_rw = rw; m1_addr = addr; m1_din = din; end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      seen = (m == 0) ? m0_ack : m1_ack;
    end
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  initial begin
    int   cyc, ack0_at, ack1_at, seq_n, n0, n1, last_cyc;
    logic overlap;

    wire_reset_n = 1'b0;
    m0_req = 0; m0_rw = 0; m0_addr = 16'h0; m0_din = 16'h0;
    m1_req = 0; m1_rw = 0; m1_addr = 16'h0; m1_din = 16'h0;
    d3_m0_req = 0; d3_m0_rw = 0; d3_m0_addr = 16'h0; d3_m0_din = 16'h0;

    // ---- reset state ----
    repeat (2) @(negedge wire_clock);
    tb_init = 1'b0;
    check("rst_ram_rw",   32'(ram_rw),   32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_din",  32'(ram_din),  32'h0);
    check("rst_m0_ack",   32'(m0_ack),   32'h0);
    check("rst_m1_ack",   32'(m1_ack),   32'h0);
    check("rst_m0_dout",  32'(m0_dout),  32'h0);
    check("rst_m1_dout",  32'(m1_dout),  32'h0);
    wire_reset_n = 1'b1;
    tick();

    // ---- single read by M0, latency 1 ----
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0000;
    tick();
    check("rd_addr_c1", 32'(ram_addr), 32'h0000);
    check("rd_rw_c1",   32'(ram_rw),   32'h0);
    check("rd_ack_c1",  32'(m0_ack),   32'h0);
    tick();
    check("rd_ack_c2",  32'(m0_ack),   32'h1);
    check("rd_m1ack_c2", 32'(m1_ack),  32'h0);
    check("rd_data_c2", 32'(m0_dout),  32'h1234);
    m0_req = 1'b0;
    tick();
    check("rd_ack_c3",  32'(m0_ack),   32'h0);
    check("rd_hold_c3", 32'(m0_dout),  32'h1234);

    // ---- single write by M1 ----
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 16'h00A0; m1_din = 16'hBEEF;
    tick();
    check("wr_rw_c1",   32'(ram_rw),   32'h1);
    check("wr_addr_c1", 32'(ram_addr), 32'h00A0);
    check("wr_din_c1",  32'(ram_din),  32'hBEEF);
    check("wr_ack_c1",  32'(m1_ack),   32'h0);
    tick();
    check("wr_rw_c2",   32'(ram_rw),   32'h0);
    check("wr_ack_c2",  32'(m1_ack),   32'h1);
    check("wr_dout_c2", 32'(m1_dout),  32'h0);
    m1_req = 1'b0;
    tick();
    check("wr_ack_c3",  32'(m1_ack),   32'h0);

    // read-back by M0
    run_one(0, 1'b0, 16'h00A0, 16'h0, cyc);
    check("rb_cycles", 32'(cyc),     32'd2);
    check("rb_data",   32'(m0_dout), 32'hBEEF);
    tick();

    // ---- reset in the middle of an M0 write ----
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 16'h0055; m0_din = 16'h5555;
    tick();
    check("rmw_rw_before", 32'(ram_rw), 32'h1);
    #2 wire_reset_n = 1'b0;
    #1;
    check("rmw_rw_async",  32'(ram_rw),   32'h0);
    check("rmw_addr_async", 32'(ram_addr), 32'h0);
    check("rmw_ack_async", 32'(m0_ack),   32'h0);
    m0_req = 1'b0;
    @(negedge wire_clock);
    #2 wire_reset_n = 1'b1;
    @(negedge wire_clock);
    check("rmw_ack_after", 32'(m0_ack),   32'h0);
    check("rmw_rw_after",  32'(ram_rw),   32'h0);
    check("rmw_dout_clr",  32'(m0_dout),  32'h0);
    check("rmw_no_write",  32'(mem[8'h55]), 32'h0);
    run_one(0, 1'b0, 16'h0010, 16'h0, cyc);
    check("rmw_next_cycles", 32'(cyc),     32'd2);
    check("rmw_next_data",   32'(m0_dout), 32'h1111);
    tick();

    // ---- simultaneous requests right after reset ----
    wire_reset_n = 1'b0;
    tick();
    wire_reset_n = 1'b1;
    tick();
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 16'h0020;
    cyc = 0; ack0_at = 0; ack1_at = 0; overlap = 1'b0;
    while ((ack0_at == 0 || ack1_at == 0) && cyc < 30) begin
      tick();
      cyc++;
      if (m0_ack && m1_ack) overlap = 1'b1;
      if (m0_ack && ack0_at == 0) begin ack0_at = cyc; m0_req = 1'b0; end
      if (m1_ack && ack1_at == 0) begin ack1_at = cyc; m1_req = 1'b0; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("sim_ack0_cycle", 32'(ack0_at), 32'd2);
    check("sim_ack1_cycle", 32'(ack1_at), 32'd5);
    check("sim_overlap",    32'(overlap), 32'h0);
    check("sim_m0_data",    32'(m0_dout), 32'h1111);
    check("sim_m1_data",    32'(m1_dout), 32'h2222);
    tick();

    // ---- continuous contention: 12 transactions, strict alternation ----
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 16'h0020;
    cyc = 0; seq_n = 0; n0 = 0; n1 = 0; last_cyc = 0; overlap = 1'b0;
    while (seq_n < 12 && cyc < 100) begin
      tick();
      cyc++;
      if (m0_ack && m1_ack) overlap = 1'b1;
      if (m0_ack) begin
        check("cont_order", 32'h0, 32'(seq_n % 2));
        n0++; seq_n++; last_cyc = cyc;
      end else if (m1_ack) begin
        check("cont_order", 32'h1, 32'(seq_n % 2));
        n1++; seq_n++; last_cyc = cyc;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("cont_n0",      32'(n0),       32'd6);
    check("cont_n1",      32'(n1),       32'd6);
    check("cont_overlap", 32'(overlap),  32'h0);
    check("cont_last",    32'(last_cyc), 32'd35);
    tick();
    check("cont_idle_ack", 32'({m1_ack, m0_ack}), 32'h0);

    // ---- READ_LATENCY = 3 read ----
    d3_m0_req = 1'b1; d3_m0_rw = 1'b0; d3_m0_addr = 16'h0042;
    cyc = 0;
    while (!d3_m0_ack && cyc < 20) begin
      tick();
      cyc++;
      if (!d3_m0_ack) begin
        check("rl3_addr_hold", 32'(d3_ram_addr), 32'h0042);
        check("rl3_rw_low",    32'(d3_ram_rw),   32'h0);
      end
    end
    d3_m0_req = 1'b0;
    check("rl3_cycles", 32'(cyc),        32'd4);
    check("rl3_data",   32'(d3_m0_dout), 32'hCAFE);
    tick();
    check("rl3_ack_low",  32'(d3_m0_ack),  32'h0);
    check("rl3_hold",     32'(d3_m0_dout), 32'hCAFE);
    check("rl3_m1_quiet", 32'({d3_m1_ack, d3_m1_dout, d3_ram_din}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
